ptmch_trg_log: RTL and testbench
================================

Name: ptmch_trg_log

Overview:
- Downstream consumer of the 5-bit instruction trigger pulse bus (TRG_PLS) from the SPI instruction matcher.
- Timestamps each trigger event with a free-running counter and queues {overflow flag, channel mask, timestamp} in a FIFO for a host/debug reader.
- Keeps per-channel saturating event counters and a drop counter.
- Single CLK160M domain; TRG_PLS is produced synchronously in this domain, so no input synchronizer is used.

Parameters:
- P_DEPTH, 16, FIFO entries; power of two, minimum 2.
- P_TS_W, 24, timestamp width in bits (wraps).
- P_CNT_W, 16, width of each event counter and of the drop counter.

Ports:
- CLK160M  in  1  160 MHz system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- TRG_PLS  in  5  trigger pulses: [0] program execute, [1] read status, [2] block erase, [3] page data read, [4] write status. Pulses are high ~15 cycles.
- CLR  in  1  synchronous clear of FIFO, counters and flags.
- RD_EN  in  1  pop request for the head entry.
- RD_VLD  out  1  head entry valid (FIFO not empty).
- RD_DATA  out  P_TS_W+6  head entry: [P_TS_W+5] OVF, [P_TS_W+4:P_TS_W] channel mask, [P_TS_W-1:0] timestamp.
- FIFO_LVL  out  $clog2(P_DEPTH)+1  current occupancy.
- FIFO_FULL  out  1  occupancy == P_DEPTH.
- EVT_CNT  out  5*P_CNT_W  packed per-channel counts; channel i at [i*P_CNT_W +: P_CNT_W].
- DROP_CNT  out  P_CNT_W  events lost because the FIFO was full.

Behaviour:
- Reset: all outputs 0. Timestamp counter, FIFO pointers, OVF sticky flag and edge registers are all 0.
- Timestamp counter: increments every cycle, wraps from all-ones to 0. CLR does not affect it.
- Edge detect: sr_trg_1d registers TRG_PLS. Edge vector = TRG_PLS & ~sr_trg_1d, evaluated combinationally.
- Event: any edge bit set. Multiple simultaneous edges produce ONE entry whose mask has all those bits set.
- Captured timestamp: counter value in the edge cycle.
- Latency: if TRG_PLS is first sampled high at clock edge k, the entry is written at edge k+1 and RD_VLD is high after edge k+1.
- FIFO is show-ahead:
  - RD_DATA always presents the head entry; RD_VLD = ~empty.
  - RD_EN & RD_VLD pops at the next edge.
  - RD_EN while empty is ignored; no underflow and no state change.
  - RD_DATA is don't-care while RD_VLD=0; the bench must not check it then.
- Full:
  - An event arriving while full and not popping in the same cycle is dropped.
  - DROP_CNT increments and saturates at all-ones.
  - The sticky OVF flag is set.
- Simultaneous push and pop while full: both take effect; level is unchanged and nothing is dropped.
- OVF: the next successfully written entry carries OVF=1, then the sticky flag clears. If a drop and a successful write occur in the same cycle, the written entry carries OVF=1.
- EVT_CNT[i]: increments on every edge of channel i, including dropped events; saturates at all-ones.
- CLR: highest priority. In the CLR cycle:
  - FIFO is emptied; EVT_CNT, DROP_CNT and OVF are cleared.
  - Any edge or pop in that cycle is discarded.
  - sr_trg_1d still updates, so a pulse already high is not re-detected afterwards.
- Reset mid-operation: immediate return to reset values; no partial entry survives.

Optional Feature:
- Macro: PTMCH_TRG_LOG_GLITCH_FLT_EN.
- Defined:
  - Each TRG_PLS bit passes a per-bit 2-bit run counter. The qualified bit asserts only after 4 consecutive high samples and deasserts on the first low sample.
  - Edge detection operates on the qualified bits, so latency grows by 3 cycles.
  - Pulses shorter than 4 cycles are ignored entirely.
  - The captured timestamp is the counter value in the qualified-edge cycle.
- Undefined: raw TRG_PLS feeds edge detection exactly as described in Behaviour.

Decomposition:
- Package ptmch_pkg:
  - Channel index constants: CH_PROG_EXEC=0, CH_RD_STATUS=1, CH_BLK_ERASE=2, CH_PAGE_READ=3, CH_WR_STATUS=4.
  - NUM_TRG_CH=5.
  - Packed struct typedef for the log entry {ovf, ch_mask[4:0], ts}, parameterised by width through a localparam default of 24.
- Sub-module ptmch_sync_fifo:
  - Parameterised width/depth, show-ahead, with push/pop/full/empty/level.
  - Simultaneous push+pop allowed when full.
  - Owns pointers and storage; ptmch_trg_log owns edge detect, timestamp, OVF and counters.

Test Plan:
- Single pulse on TRG_PLS[2] (15 cycles high) with counter at 100 when first sampled → one entry {OVF=0, mask=5'b00100, ts=100}; EVT_CNT ch2=1; RD_VLD high after the next edge; second entry not created during the pulse.
- TRG_PLS[0] and [3] rising in the same cycle → exactly one entry, mask=5'b01001; EVT_CNT ch0=1 and ch3=1; FIFO_LVL=1.
- 18 separate pulses on ch1 with no reads (P_DEPTH=16) → FIFO_FULL=1, FIFO_LVL=16, DROP_CNT=2, EVT_CNT ch1=18. Pop one, inject a pulse → new tail entry has OVF=1; the following entry has OVF=0.
- FIFO full with RD_EN=1 and a new edge in the same cycle → level stays 16, DROP_CNT unchanged, head advances, new entry at tail.
- Timestamp wrap (P_TS_W=4): pulses at counter 14 and 1 after wrap → entries ts=14 then ts=1, in order.
- CLR asserted in the same cycle as an edge with 3 queued entries → RD_VLD=0, FIFO_LVL=0, all counters 0, no entry created. With PTMCH_TRG_LOG_GLITCH_FLT_EN defined, a 3-cycle pulse creates no entry and a 4-cycle pulse creates one.

Source files
------------

// File: rtl/ptmch_pkg.sv
// Shared channel indices and log-entry layout for the trigger logger.
package ptmch_pkg;

  localparam int CH_PROG_EXEC = 0;
  localparam int CH_RD_STATUS = 1;
  localparam int CH_BLK_ERASE = 2;
  localparam int CH_PAGE_READ = 3;
  localparam int CH_WR_STATUS = 4;
  localparam int NUM_TRG_CH   = 5;

  localparam int LOG_TS_W = 24;

  typedef struct packed {
    logic                  ovf;
    logic [NUM_TRG_CH-1:0] ch_mask;
    logic [LOG_TS_W-1:0]   ts;
  } trg_log_entry_t;

endpackage

// File: rtl/ptmch_sync_fifo.sv
// Show-ahead synchronous FIFO; write-to-visible is one cycle, head is visible combinationally.
// A push while full is accepted only when a pop happens in the same cycle; clr has priority.
module ptmch_sync_fifo #(
  parameter int P_W     = 8,
  parameter int P_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [P_W-1:0]             wdata,
  input  logic                       pop,
  output logic [P_W-1:0]             rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(P_DEPTH):0]   level
);

  localparam int AW = $clog2(P_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(P_DEPTH);

  logic [P_W-1:0] mem [P_DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Zero the head while empty so the output is deterministic out of reset.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~clr) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ptmch_trg_log.sv
// Timestamped trigger-event logger: edge at sample k is logged at edge k+1 (k+4 with PTMCH_TRG_LOG_GLITCH_FLT_EN).
// No backpressure on triggers: events arriving while the FIFO is full are dropped, counted and flagged via OVF.
module ptmch_trg_log
  import ptmch_pkg::*;
#(
  parameter int P_DEPTH = 16,
  parameter int P_TS_W  = 24,
  parameter int P_CNT_W = 16
) (
  input  logic                          CLK160M,
  input  logic                          RESET_N,
  input  logic [NUM_TRG_CH-1:0]         TRG_PLS,
  input  logic                          CLR,
  input  logic                          RD_EN,
  output logic                          RD_VLD,
  output logic [P_TS_W+5:0]             RD_DATA,
  output logic [$clog2(P_DEPTH):0]      FIFO_LVL,
  output logic                          FIFO_FULL,
  output logic [NUM_TRG_CH*P_CNT_W-1:0] EVT_CNT,
  output logic [P_CNT_W-1:0]            DROP_CNT
);

  logic [P_TS_W-1:0]     ts_cnt;
  logic [NUM_TRG_CH-1:0] trg_q;
  logic [NUM_TRG_CH-1:0] sr_trg_1d;
  logic [NUM_TRG_CH-1:0] edge_vec;
  logic                  stg_vld;
  logic [NUM_TRG_CH-1:0] stg_mask;
  logic [P_TS_W-1:0]     stg_ts;
  logic                  ovf_flag;
  logic [P_CNT_W-1:0]    drop_cnt;
  logic [P_CNT_W-1:0]    evt_cnt [NUM_TRG_CH];
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop_req;
  logic                  push_ok;
  logic                  drop;

`ifdef PTMCH_TRG_LOG_GLITCH_FLT_EN
  // Run counter saturates at 3; the fourth consecutive high sample qualifies the bit.
  logic [1:0] run_cnt [NUM_TRG_CH];

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_TRG_CH; i++) run_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TRG_CH; i++) begin
        if (!TRG_PLS[i])              run_cnt[i] <= '0;
        else if (run_cnt[i] != 2'd3)  run_cnt[i] <= run_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    trg_q = '0;
    for (int i = 0; i < NUM_TRG_CH; i++) trg_q[i] = TRG_PLS[i] & (run_cnt[i] == 2'd3);
  end
`else
  assign trg_q = TRG_PLS;
`endif

  assign edge_vec = trg_q & ~sr_trg_1d;

  assign pop_req = RD_EN & ~fifo_empty & ~CLR;
  assign push_ok = stg_vld & ~CLR & (~fifo_full | pop_req);
  assign drop    = stg_vld & ~CLR & fifo_full & ~pop_req;

  // The edge is staged one cycle with its timestamp, then written or dropped.
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      ts_cnt    <= '0;
      sr_trg_1d <= '0;
      stg_vld   <= 1'b0;
      stg_mask  <= '0;
      stg_ts    <= '0;
      ovf_flag  <= 1'b0;
      drop_cnt  <= '0;
      for (int i = 0; i < NUM_TRG_CH; i++) evt_cnt[i] <= '0;
    end else begin
      ts_cnt    <= ts_cnt + 1'b1;
      sr_trg_1d <= trg_q;
      stg_mask  <= edge_vec;
      stg_ts    <= ts_cnt;
      if (CLR) begin
        stg_vld  <= 1'b0;
        ovf_flag <= 1'b0;
        drop_cnt <= '0;
        for (int i = 0; i < NUM_TRG_CH; i++) evt_cnt[i] <= '0;
      end else begin
        stg_vld <= |edge_vec;
        if (drop) begin
          ovf_flag <= 1'b1;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end else if (push_ok) begin
          ovf_flag <= 1'b0;
        end
        for (int i = 0; i < NUM_TRG_CH; i++) begin
          if (stg_vld && stg_mask[i] && (evt_cnt[i] != '1)) evt_cnt[i] <= evt_cnt[i] + 1'b1;
        end
      end
    end
  end

  ptmch_sync_fifo #(
    .P_W     (P_TS_W + 6),
    .P_DEPTH (P_DEPTH)
  ) u_fifo (
    .clk   (CLK160M),
    .rst_n (RESET_N),
    .clr   (CLR),
    .push  (push_ok),
    .wdata ({ovf_flag, stg_mask, stg_ts}),
    .pop   (pop_req),
    .rdata (RD_DATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (FIFO_LVL)
  );

  assign RD_VLD    = ~fifo_empty;
  assign FIFO_FULL = fifo_full;
  assign DROP_CNT  = drop_cnt;

  for (genvar g = 0; g < NUM_TRG_CH; g++) begin : g_evt
    assign EVT_CNT[g*P_CNT_W +: P_CNT_W] = evt_cnt[g];
  end

endmodule

// File: tb/tb_ptmch_trg_log.sv
// Scoreboard bench for ptmch_trg_log: default instance plus a 4-bit timestamp instance for wrap ordering.
`timescale 1ns/1ps
module tb_ptmch_trg_log;

`ifdef PTMCH_TRG_LOG_GLITCH_FLT_EN
  localparam int LAT    = 4;
  localparam int TS_OFF = 3;
`else
  localparam int LAT    = 1;
  localparam int TS_OFF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  trg = '0;
  logic        clr = 1'b0;
  logic        rd_en = 1'b0;
  logic        rd_vld;
  logic [29:0] rd_data;
  logic [4:0]  lvl;
  logic        full;
  logic [79:0] evt;
  logic [15:0] drop;

  logic [4:0]  trg_w = '0;
  logic        rd_en_w = 1'b0;
  logic        clr_w = 1'b0;
  logic        rd_vld_w;
  logic [9:0]  rd_data_w;
  logic [2:0]  lvl_w;
  logic        full_w;
  logic [79:0] evt_w;
  logic [15:0] drop_w;

  logic [23:0] m_ts;
  logic [29:0] exp_q [$];
  logic [9:0]  exp_w [$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ptmch_trg_log u_dut (
    .CLK160M(clk), .RESET_N(rst_n), .TRG_PLS(trg), .CLR(clr), .RD_EN(rd_en),
    .RD_VLD(rd_vld), .RD_DATA(rd_data), .FIFO_LVL(lvl), .FIFO_FULL(full),
    .EVT_CNT(evt), .DROP_CNT(drop)
  );

  ptmch_trg_log #(.P_DEPTH(4), .P_TS_W(4), .P_CNT_W(16)) u_dut_w (
    .CLK160M(clk), .RESET_N(rst_n), .TRG_PLS(trg_w), .CLR(clr_w), .RD_EN(rd_en_w),
    .RD_VLD(rd_vld_w), .RD_DATA(rd_data_w), .FIFO_LVL(lvl_w), .FIFO_FULL(full_w),
    .EVT_CNT(evt_w), .DROP_CNT(drop_w)
  );

  // Free-running reference timestamp: the value present during the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_ts <= '0;
    else        m_ts <= m_ts + 24'd1;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_vld && rd_en) begin
      if (exp_q.size() == 0) check("pop_unexpected", {34'd0, rd_data}, 64'hdead);
      else                   check("pop_entry", {34'd0, rd_data}, {34'd0, exp_q.pop_front()});
    end
    if (rst_n && rd_vld_w && rd_en_w) begin
      if (exp_w.size() == 0) check("wrap_unexpected", {54'd0, rd_data_w}, 64'hdead);
      else                   check("wrap_entry", {54'd0, rd_data_w}, {54'd0, exp_w.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (6) tick();
  endtask

  task automatic pulse(input logic [4:0] m, input int len, input logic ovf, input logic store);
    if (store) exp_q.push_back({ovf, m, m_ts + 24'(TS_OFF)});
    trg = m;
    repeat (len) tick();
    trg = '0;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    rd_en = 1'b1;
    while (rd_vld && n < 40) begin
      tick();
      n++;
    end
    rd_en = 1'b0;
    check("drain_vld", rd_vld, 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) tick();
    check("rst_vld", rd_vld, 0);
    check("rst_data", rd_data, 0);
    check("rst_lvl", lvl, 0);
    check("rst_full", full, 0);
    check("rst_evt", evt, 0);
    check("rst_drop", drop, 0);
    rst_n = 1'b1;

    // Single 15-cycle pulse on ch2 captured at ts=100.
    n = 0;
    while ((m_ts + 24'(TS_OFF)) != 24'd100 && n < 300) begin tick(); n++; end
    check("t1_wait", n < 300, 1);
    exp_q.push_back({1'b0, 5'b00100, 24'd100});
    trg = 5'b00100;
    repeat (LAT) tick();
    check("t1_vld_early", rd_vld, 0);
    tick();
    check("t1_vld", rd_vld, 1);
    check("t1_lvl", lvl, 1);
    repeat (14 - LAT) tick();
    trg = '0;
    settle();
    check("t1_one_entry", lvl, 1);
    check("t1_evt2", evt[2*16 +: 16], 1);
    drain();

    // Simultaneous rising edges on ch0 and ch3 make one entry.
    pulse(5'b01001, 15, 1'b0, 1'b1);
    settle();
    check("t2_lvl", lvl, 1);
    check("t2_evt0", evt[0 +: 16], 1);
    check("t2_evt3", evt[3*16 +: 16], 1);
    drain();

    // Overflow: 18 pulses into 16 entries.
    for (int i = 0; i < 18; i++) pulse(5'b00010, 5, 1'b0, i < 16);
    settle();
    check("t3_full", full, 1);
    check("t3_lvl", lvl, 16);
    check("t3_drop", drop, 2);
    check("t3_evt1", evt[16 +: 16], 18);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    pulse(5'b00010, 5, 1'b1, 1'b1);
    settle();
    check("t3_refull", lvl, 16);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    pulse(5'b00010, 5, 1'b0, 1'b1);
    settle();

    // Push and pop in the same cycle while full.
    exp_q.push_back({1'b0, 5'b00010, m_ts + 24'(TS_OFF)});
    trg = 5'b00010;
    repeat (LAT) tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t4_lvl", lvl, 16);
    check("t4_full", full, 1);
    check("t4_drop", drop, 2);
    repeat (4) tick();
    trg = '0;
    settle();
    check("t4_evt1", evt[16 +: 16], 21);
    drain();

    // Timestamp wrap on the 4-bit instance.
    n = 0;
    while (((m_ts + 24'(TS_OFF)) & 24'hf) != 24'd14 && n < 40) begin tick(); n++; end
    exp_w.push_back({1'b0, 5'b00001, 4'd14});
    trg_w = 5'b00001; repeat (5) tick(); trg_w = '0; tick();
    while (((m_ts + 24'(TS_OFF)) & 24'hf) != 24'd1 && n < 80) begin tick(); n++; end
    check("wrap_wait", n < 80, 1);
    exp_w.push_back({1'b0, 5'b00001, 4'd1});
    trg_w = 5'b00001; repeat (5) tick(); trg_w = '0; tick();
    settle();
    check("wrap_lvl", lvl_w, 2);
    n = 0;
    rd_en_w = 1'b1;
    while (rd_vld_w && n < 10) begin tick(); n++; end
    rd_en_w = 1'b0;
    check("wrap_queue", exp_w.size(), 0);

    // CLR in the same cycle as an edge with three entries queued.
    for (int i = 0; i < 3; i++) pulse(5'b10000, 5, 1'b0, 1'b1);
    settle();
    check("t5_pre_lvl", lvl, 3);
    trg = 5'b00001;
    repeat (LAT - 1) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    exp_q.delete();
    repeat (5) tick();
    trg = '0;
    settle();
    check("t5_vld", rd_vld, 0);
    check("t5_lvl", lvl, 0);
    check("t5_evt", evt, 0);
    check("t5_drop", drop, 0);

    // Reset mid-operation discards the queued entry.
    pulse(5'b00100, 5, 1'b0, 1'b1);
    settle();
    check("t6_pre_lvl", lvl, 1);
    rst_n = 1'b0;
    #1;
    check("t6_vld", rd_vld, 0);
    check("t6_lvl", lvl, 0);
    check("t6_evt", evt, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef PTMCH_TRG_LOG_GLITCH_FLT_EN
    pulse(5'b01000, 3, 1'b0, 1'b0);
    settle();
    check("flt_short", lvl, 0);
    pulse(5'b01000, 4, 1'b0, 1'b1);
    settle();
    check("flt_long", lvl, 1);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
